// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a write FIFO, configurable data width,
// runtime-selectable parity (none/even/odd) and one or two stop bits.
// Bit timing comes from an external baud tick, one clk-wide pulse per bit.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    output logic                 tx_busy,
    output logic [CW-1:0]        fifo_count,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic                 overflow_reg;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head;

    // A push is only accepted while not full; a pop in the same cycle does
    // not free a slot early, so a push against a full FIFO is always dropped.
    assign tx_ready   = (count_reg != FULL_COUNT);
    assign push       = tx_start && tx_ready;
    assign fifo_empty = (count_reg == '0);
    assign head       = mem[rd_ptr_reg];
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

    // FIFO storage: written on accepted pushes only (no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            overflow_reg <= tx_start && !tx_ready;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t               state_reg,    state_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic [BW-1:0]        bit_cnt_reg,  bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 par_en_reg,   par_en_next;
    logic                 par_bit_reg,  par_bit_next;
    logic                 stop2_reg,    stop2_next;
    logic                 tx_reg,       tx_next;
    logic                 done_reg,     done_next;

    assign tx      = tx_reg;
    assign tx_done = done_reg;
    assign tx_busy = (state_reg != IDLE);

    // FSM and datapath registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            stop2_reg    <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
            stop2_reg    <= stop2_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic: every transition is qualified by the baud tick
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
        stop2_next    = stop2_reg;
        done_next     = 1'b0;
        pop           = 1'b0;

        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end
                end
                START: begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
                DATA: begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        stop_cnt_next = 1'b0;
                        state_next    = par_en_reg ? PARITY : STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
                PARITY: begin
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end
                STOP: begin
                    if (stop2_reg && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        // Frame end: chain straight into the next frame if queued
                        done_next = 1'b1;
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Popping loads the frame and samples the config for this frame only
        if (pop) begin
            shift_next   = head;
            par_en_next  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_next = (^head) ^ (parity_mode == 2'b10);
            stop2_next   = stop2;
        end

        // Line level registered from the state being entered
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit_next;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo (8-bit and 5-bit instances).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [1:0] parity_mode;
    logic       stop2;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready, tx, tx_done, tx_busy, overflow;
    logic [2:0] fifo_count;

    logic       tx_start5;
    logic [4:0] tx_data5;
    logic       tx_ready5, tx5, tx_done5, tx_busy5, overflow5;
    logic [2:0] fifo_count5;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(tx_start),
        .tx_data(tx_data), .parity_mode(parity_mode), .stop2(stop2),
        .tx_ready(tx_ready), .tx(tx), .tx_done(tx_done), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(tx_start5),
        .tx_data(tx_data5), .parity_mode(parity_mode), .stop2(stop2),
        .tx_ready(tx_ready5), .tx(tx5), .tx_done(tx_done5), .tx_busy(tx_busy5),
        .fifo_count(fifo_count5), .overflow(overflow5)
    );

    // Pulse counters for the 8-bit instance
    always @(posedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    // One baud tick every 16 clks; returns at the negedge right after the tick edge
    task automatic do_tick;
        repeat (15) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (tx5 !== 1'b1 || tx_ready5 !== 1'b1 || overflow5 !== 1'b0 || fifo_count5 !== 3'd0)
            begin errors++; $display("FAIL reset_dut5: got tx=%b rdy=%b ovf=%b cnt=%0d expected 1 1 0 0", tx5, tx_ready5, overflow5, fifo_count5); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_8n1;
        logic exp [10];
        int   d0;
        exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        parity_mode = 2'b00;
        stop2 = 1'b0;
        push_byte(8'hA5);
        d0 = done_cnt;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL 8n1_count_push: got %0d expected 1", fifo_count); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_pre: got %b expected 0", tx_busy); end
        for (int i = 0; i < 10; i++) begin
            do_tick;
            checks++; if (tx !== exp[i]) begin errors++; $display("FAIL 8n1_bit%0d: got %b expected %b", i, tx, exp[i]); end
            checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL 8n1_busy%0d: got %b expected 1", i, tx_busy); end
            checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL 8n1_done_early%0d: got %b expected 0", i, tx_done); end
        end
        do_tick;
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL 8n1_done: got %b expected 1", tx_done); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_end: got %b expected 0", tx_busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL 8n1_idle: got %b expected 1", tx); end
        @(negedge clk);
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL 8n1_done_width: got %b expected 0", tx_done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 8n1_done_count: got %0d expected 1", done_cnt - d0); end
        $display("8n1: frame 0xA5 sent");
    endtask

    task automatic test_parity(input logic [1:0] mode, input logic pbit, input string name);
        logic exp [11];
        exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, pbit, 1'b1};
        parity_mode = mode;
        stop2 = 1'b0;
        push_byte(8'hA5);
        for (int i = 0; i < 11; i++) begin
            do_tick;
            // Config change mid-frame must not affect the frame in flight
            if (i == 0) parity_mode = 2'b00;
            checks++; if (tx !== exp[i]) begin errors++; $display("FAIL %s_bit%0d: got %b expected %b", name, i, tx, exp[i]); end
        end
        do_tick;
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, tx_done); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b expected 0", name, tx_busy); end
        $display("%s: 11-bit frame 0xA5 sent", name);
    endtask

    task automatic test_back_to_back;
        logic exp [22];
        exp = '{1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1,
                1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1};
        parity_mode = 2'b00;
        stop2 = 1'b1;
        push_byte(8'h00);
        push_byte(8'hFF);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count2: got %0d expected 2", fifo_count); end
        for (int i = 0; i < 22; i++) begin
            do_tick;
            checks++; if (tx !== exp[i]) begin errors++; $display("FAIL b2b_bit%0d: got %b expected %b", i, tx, exp[i]); end
            if (i == 0) begin
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count1: got %0d expected 1", fifo_count); end
            end
            if (i == 11) begin
                checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_count0: got %0d expected 0", fifo_count); end
                checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", tx_done); end
                checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_gap: got %b expected 1", tx_busy); end
            end
        end
        do_tick;
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", tx_done); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", tx_busy); end
        stop2 = 1'b0;
        $display("back_to_back: 0x00 and 0xFF sent with two stop bits");
    endtask

    task automatic test_overflow;
        logic [7:0] d [5];
        logic [7:0] got;
        logic       exp_next;
        int         d0;
        int         o0;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        parity_mode = 2'b00;
        stop2 = 1'b0;
        o0 = ovf_cnt;
        tx_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = d[i];
            @(negedge clk);
        end
        tx_start = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b expected 0", tx_ready); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b expected 0", overflow); end
        checks++; if (ovf_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt - o0); end
        d0 = done_cnt;
        do_tick;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL ovf_start0: got %b expected 0", tx); end
        for (int f = 0; f < 4; f++) begin
            got = 8'h00;
            for (int b = 0; b < 8; b++) begin
                do_tick;
                got[b] = tx;
            end
            checks++; if (got !== d[f]) begin errors++; $display("FAIL ovf_frame%0d: got %h expected %h", f, got, d[f]); end
            do_tick;
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ovf_stop%0d: got %b expected 1", f, tx); end
            do_tick;
            exp_next = (f < 3) ? 1'b0 : 1'b1;
            checks++; if (tx !== exp_next) begin errors++; $display("FAIL ovf_next%0d: got %b expected %b", f, tx, exp_next); end
            $display("overflow: frame %0d got 0x%h", f, got);
        end
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 4) begin errors++; $display("FAIL ovf_frames: got %0d expected 4", done_cnt - d0); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_count_end: got %0d expected 0", fifo_count); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_end: got %b expected 1", tx_ready); end
    endtask

    task automatic test_5bit;
        logic exp [8];
        exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        parity_mode = 2'b10;
        tx_start5 = 1'b1;
        tx_data5  = 5'h1F;
        @(negedge clk);
        tx_start5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_tick;
            checks++; if (tx5 !== exp[i]) begin errors++; $display("FAIL 5bit_bit%0d: got %b expected %b", i, tx5, exp[i]); end
        end
        do_tick;
        checks++; if (tx_done5 !== 1'b1) begin errors++; $display("FAIL 5bit_done: got %b expected 1", tx_done5); end
        checks++; if (tx_busy5 !== 1'b0) begin errors++; $display("FAIL 5bit_busy_end: got %b expected 0", tx_busy5); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL 5bit_main_idle: got %b expected 1", tx); end
        parity_mode = 2'b00;
        $display("5bit: frame 0x1F odd parity sent");
    endtask

    task automatic test_reset_mid_frame;
        int   d0;
        logic low_seen;
        parity_mode = 2'b00;
        tx_start = 1'b1;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        tx_start = 1'b0;
        repeat (3) do_tick;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b expected 0", tx); end
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", fifo_count); end
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d expected 0", fifo_count); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", tx_busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_tick;
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        @(negedge clk);
        checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL rst_line_idle: got low_seen=%b expected 0", low_seen); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", done_cnt - d0); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count_after: got %0d expected 0", fifo_count); end
        $display("reset_mid_frame: queue discarded, line idle");
    endtask

    initial begin
        rst_n       = 1'b0;
        tick        = 1'b0;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        tx_start5   = 1'b0;
        tx_data5    = 5'h00;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        test_reset;
        test_8n1;
        test_parity(2'b01, 1'b0, "even");
        test_parity(2'b10, 1'b1, "odd");
        test_back_to_back;
        test_overflow;
        test_5bit;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the next generation of the team's `uart_tx`. It adds a write FIFO, a configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. The block is driven by the shared external baud tick (one pulse per bit time). It sits between a bus-side register block that pushes bytes and the serial TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, write FIFO entries; power of 2, 2..16.
CW, $clog2(FIFO_DEPTH+1), derived width of fifo_count; not to be overridden.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
tick  input  1  baud tick, one clk-wide pulse per bit time.
tx_start  input  1  push request; tx_data is written when tx_start=1 and tx_ready=1.
tx_data  input  DATA_BITS  byte to push.
parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
stop2  input  1  0=one stop bit, 1=two stop bits.
tx_ready  output  1  FIFO not full.
tx  output  1  serial line; idles high.
tx_done  output  1  one-clk pulse at the end of each frame.
tx_busy  output  1  FSM not in IDLE.
fifo_count  output  CW  current FIFO occupancy.
overflow  output  1  one-clk pulse when tx_start=1 while FIFO full; the data is dropped.

Behaviour:
- Clock and reset: single clock clk; reset rst_n, asynchronous, active-low.
- Reset values: tx=1, tx_done=0, tx_busy=0, overflow=0, fifo_count=0, tx_ready=1. FSM=IDLE, FIFO pointers cleared.
- Reset asserted mid-frame: tx returns to 1 immediately (async) and all queued data is discarded.
- FIFO: push when tx_start && tx_ready. Pop happens only inside the FSM.
  - A push while full is dropped even if a pop occurs in the same cycle; overflow pulses.
  - Simultaneous push and pop when not full: count unchanged.
  - fifo_count and tx_ready update on the clock after the event.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on clk edges where tick=1.
  - IDLE: tx=1. On tick with count>0: pop the head entry into the shift register and latch parity_mode/stop2 for the frame. Go to START; tx=0 from the next clk.
  - START -> DATA on tick. tx = shift[0] (LSB first). Bit counter = 0.
  - DATA: each tick shifts right and increments the bit counter. After DATA_BITS bits, go to PARITY if the latched mode is even/odd, else go to STOP.
  - PARITY bit value:
    - even: XOR of the data bits;
    - odd: inverted XOR of the data bits.
  - STOP: tx=1 for 1 or 2 tick periods per the latched stop2.
- Frame end (the tick that ends the last stop bit):
  - tx_done=1 for exactly that clk.
  - If count>0: pop in the same cycle and go directly to START, with no idle gap between frames.
  - Else go to IDLE.
- Config changes during a frame take effect only at the next frame's pop.
- tx_busy=1 in every state except IDLE.
- A tick received while in IDLE with an empty FIFO has no effect.

Test Plan:
- 8N1, push 0xA5, tick every 16 clks -> tx per tick: 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at the end of the stop bit. tx_busy covers exactly 10 bit periods.
- Even parity, push 0xA5 -> parity bit 0 after d7, 11-bit frame. Odd parity, same byte -> parity bit 1.
- stop2=1, push 0x00 then 0xFF back-to-back -> two stop bits of 1, then the next start bit with no idle tick. tx_done fires twice; fifo_count steps 2→1→0.
- Push 5 bytes in 5 consecutive clks with no ticks, FIFO_DEPTH=4 -> fifo_count=4, tx_ready=0, overflow pulses on the 5th push. Only 4 frames are transmitted.
- DATA_BITS=5, push 0x1F with odd parity -> start, 1,1,1,1,1, parity 0, stop.
- Assert rst_n during DATA of frame 1 with 2 entries queued -> tx=1 asynchronously, fifo_count=0, no tx_done. After release, the line stays idle.
